controller_input_dispatch: RTL

Receive-side counterpart of the controller transmit scheduler. Accepts the single 9-bit TSMP byte stream from the controller port (bit 8 = last byte) and classifies each frame by its TSMP ethertype and subtype. It then writes the whole frame into one of four per-consumer FIFOs: NMA, OSP, TFP or POP. Frames with no valid destination, frames that are too short, and frames whose destination FIFO lacks room are dropped whole and counted.

---
 rtl/tsmp_agent_pkg.sv | 41 ++++
 rtl/tsmp_byte_delay_line.sv | 67 ++++++
 rtl/controller_input_dispatch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tsmp_agent_pkg.sv
// Shared definitions for the TSMP receive path.
// Holds the destination encoding, the frame-header constants used by the
// classifier, and the subtype-to-destination mapping helper.
package tsmp_agent_pkg;

    // Bytes 0..14 must be seen before a frame can be classified.
    localparam int HEAD_LEN    = 15;
    // The delay line is one shorter than the header so byte 0 leaves the line
    // in the same cycle byte 14 arrives.
    localparam int DELAY_DEPTH = HEAD_LEN - 1;
    localparam int BYTE_W      = 9;
    localparam int LAST_BIT    = 8;

    localparam logic [15:0] TSMP_ETYPE = 16'hFF01;

    typedef enum logic [2:0] {
        DEST_NONE = 3'd0,
        DEST_NMA  = 3'd1,
        DEST_OSP  = 3'd2,
        DEST_TFP  = 3'd3,
        DEST_POP  = 3'd4
    } dest_e;

    localparam logic [3:0] SUBTYPE_NMA = 4'h0;
    localparam logic [3:0] SUBTYPE_OSP = 4'h1;
    localparam logic [3:0] SUBTYPE_TFP = 4'h2;
    localparam logic [3:0] SUBTYPE_POP = 4'h3;

    function automatic dest_e subtype_to_dest(input logic [3:0] subtype);
        dest_e dest;
        case (subtype)
            SUBTYPE_NMA: dest = DEST_NMA;
            SUBTYPE_OSP: dest = DEST_OSP;
            SUBTYPE_TFP: dest = DEST_TFP;
            SUBTYPE_POP: dest = DEST_POP;
            default:     dest = DEST_NONE;
        endcase
        return dest;
    endfunction

endpackage

// File: rtl/tsmp_byte_delay_line.sv
// Fixed-depth shift line of {valid, data} stages that advances every cycle.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_valid, iv_data  entry into stage 0
//   i_force_last      sets bit FORCE_BIT of stage 0's value as it moves on,
//                     used to terminate a frame that was cut short
//   ov_head_data      {stage 1, stage 0} data, for header inspection
//   o_tail_valid, ov_tail_data  last stage (oldest entry)
module tsmp_byte_delay_line #(
    parameter int DEPTH     = 14,
    parameter int WIDTH     = 10,
    parameter int FORCE_BIT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     iv_data,
    input  logic                 i_force_last,
    output logic [2*WIDTH-1:0]   ov_head_data,
    output logic                 o_tail_valid,
    output logic [WIDTH-1:0]     ov_tail_data
);

    logic [WIDTH-1:0] stage0_fwd;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             valid_d;
            logic             valid_q;
            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] data_q;

            if (gi == 0) begin : g_first
                assign valid_d = i_valid;
                assign data_d  = iv_data;
            end else if (gi == 1) begin : g_second
                assign valid_d = g_stage[0].valid_q;
                assign data_d  = stage0_fwd;
            end else begin : g_rest
                assign valid_d = g_stage[gi-1].valid_q;
                assign data_d  = g_stage[gi-1].data_q;
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end
        end
    endgenerate

    always_comb begin
        stage0_fwd = g_stage[0].data_q;
        if (i_force_last) begin
            stage0_fwd[FORCE_BIT] = 1'b1;
        end
    end

    assign ov_head_data = {g_stage[1].data_q, g_stage[0].data_q};
    assign o_tail_valid = g_stage[DEPTH-1].valid_q;
    assign ov_tail_data = g_stage[DEPTH-1].data_q;

endmodule

// File: rtl/controller_input_dispatch.sv
// Receive-side dispatcher for the controller TSMP byte stream.
// Classifies each frame on its ethertype (bytes 12-13) and subtype
// (byte 14 high nibble) and writes the whole frame to one of four consumer
// FIFOs, or drops it whole. Bytes reach the FIFO port 15 cycles after input.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   iv_data, i_data_wr      input byte stream, [8] = last byte of frame
//   i_fifo_afull_*          destination cannot take a maximum-length frame
//   ov_fifo_wdata           shared FIFO write data (0 when idle)
//   o_fifo_wr_*             one-hot write enables
//   ov_rx_pkt_cnt           frames received
//   ov_drop_pkt_cnt         frames dropped
//   o_format_err            pulse on a short or truncated frame
module controller_input_dispatch
    import tsmp_agent_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [8:0]  iv_data,
    input  logic        i_data_wr,
    input  logic        i_fifo_afull_nma,
    input  logic        i_fifo_afull_osp,
    input  logic        i_fifo_afull_tfp,
    input  logic        i_fifo_afull_pop,
    output logic [8:0]  ov_fifo_wdata,
    output logic        o_fifo_wr_nma,
    output logic        o_fifo_wr_osp,
    output logic        o_fifo_wr_tfp,
    output logic        o_fifo_wr_pop,
    output logic [15:0] ov_rx_pkt_cnt,
    output logic [15:0] ov_drop_pkt_cnt,
    output logic        o_format_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_FWD     = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    // Each line entry carries a start-of-frame tag above the 9-bit byte so the
    // destination can switch exactly when a new frame's byte 0 leaves.
    localparam int         LINE_W       = BYTE_W + 1;
    localparam logic [3:0] CLASSIFY_IDX = 4'(HEAD_LEN - 1);

    state_e      state_q, state_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    dest_e       dest_q, dest_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        format_err_q, format_err_d;
    logic [8:0]  wdata_q, wdata_d;
    logic [3:0]  wr_q, wr_d;

    logic              in_last;
    logic              line_sof;
    logic [2*LINE_W-1:0] head_data;
    logic              tail_valid;
    logic [LINE_W-1:0] tail_data;
    logic              force_last;

    logic              classify;
    logic              rx_inc;
    logic              drop_inc;
    dest_e             sub_dest;
    dest_e             class_dest;
    dest_e             eff_dest;
    logic              afull_sel;
    logic [15:0]       etype_seen;
    logic [3:0]        cnt_sat_inc;
    logic              unused_head_bits;

    assign in_last  = iv_data[LAST_BIT];
    // Any byte accepted while idle opens a new frame.
    assign line_sof = (state_q == ST_IDLE);

    tsmp_byte_delay_line #(
        .DEPTH     (DELAY_DEPTH),
        .WIDTH     (LINE_W),
        .FORCE_BIT (LAST_BIT)
    ) u_delay_line (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_data_wr),
        .iv_data      ({line_sof, iv_data}),
        .i_force_last (force_last),
        .ov_head_data (head_data),
        .o_tail_valid (tail_valid),
        .ov_tail_data (tail_data)
    );

    // When byte 14 is at the input, byte 13 sits in stage 0 and byte 12 in stage 1.
    assign etype_seen       = {head_data[LINE_W +: 8], head_data[7:0]};
    assign unused_head_bits = ^{head_data[2*LINE_W-1 -: 2], head_data[LINE_W-1 -: 2]};
    assign cnt_sat_inc      = (byte_cnt_q == 4'hF) ? 4'hF : byte_cnt_q + 4'd1;

    // Classification result for the byte currently at the input.
    always_comb begin
        sub_dest   = subtype_to_dest(iv_data[7:4]);
        afull_sel  = 1'b0;
        case (sub_dest)
            DEST_NMA: afull_sel = i_fifo_afull_nma;
            DEST_OSP: afull_sel = i_fifo_afull_osp;
            DEST_TFP: afull_sel = i_fifo_afull_tfp;
            DEST_POP: afull_sel = i_fifo_afull_pop;
            default:  afull_sel = 1'b0;
        endcase
        class_dest = DEST_NONE;
        if ((etype_seen == TSMP_ETYPE) && (sub_dest != DEST_NONE) && !afull_sel) begin
            class_dest = sub_dest;
        end
    end

    // Frame-level state machine.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        rx_inc       = 1'b0;
        drop_inc     = 1'b0;
        format_err_d = 1'b0;
        classify     = 1'b0;
        force_last   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_data_wr) begin
                    if (in_last) begin
                        // Single-byte frame: too short to classify.
                        rx_inc       = 1'b1;
                        drop_inc     = 1'b1;
                        format_err_d = 1'b1;
                        byte_cnt_d   = 4'd0;
                    end else begin
                        state_d    = ST_HEAD;
                        byte_cnt_d = 4'd1;
                    end
                end
            end
            ST_HEAD: begin
                if (!i_data_wr) begin
                    rx_inc       = 1'b1;
                    drop_inc     = 1'b1;
                    format_err_d = 1'b1;
                    state_d      = ST_IDLE;
                    byte_cnt_d   = 4'd0;
                end else if (byte_cnt_q == CLASSIFY_IDX) begin
                    classify = 1'b1;
                    rx_inc   = 1'b1;
                    drop_inc = (class_dest == DEST_NONE);
                    if (in_last) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 4'd0;
                    end else begin
                        state_d    = (class_dest == DEST_NONE) ? ST_DISCARD : ST_FWD;
                        byte_cnt_d = cnt_sat_inc;
                    end
                end else if (in_last) begin
                    rx_inc       = 1'b1;
                    drop_inc     = 1'b1;
                    format_err_d = 1'b1;
                    state_d      = ST_IDLE;
                    byte_cnt_d   = 4'd0;
                end else begin
                    byte_cnt_d = cnt_sat_inc;
                end
            end
            ST_FWD, ST_DISCARD: begin
                if (!i_data_wr) begin
                    // Truncated frame; close off what was already forwarded.
                    format_err_d = 1'b1;
                    force_last   = (state_q == ST_FWD);
                    state_d      = ST_IDLE;
                    byte_cnt_d   = 4'd0;
                end else if (in_last) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 4'd0;
                end else begin
                    byte_cnt_d = cnt_sat_inc;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                byte_cnt_d = 4'd0;
            end
        endcase
    end

    // A frame's byte 0 either leaves together with its classification, or
    // (short/truncated in header) leaves unclassified and must be discarded.
    always_comb begin
        eff_dest = dest_q;
        if (tail_valid && tail_data[LINE_W-1]) begin
            eff_dest = classify ? class_dest : DEST_NONE;
        end
        dest_d = (tail_valid && tail_data[LINE_W-1]) ? eff_dest : dest_q;

        wr_d = 4'b0000;
        if (tail_valid) begin
            case (eff_dest)
                DEST_NMA: wr_d = 4'b0001;
                DEST_OSP: wr_d = 4'b0010;
                DEST_TFP: wr_d = 4'b0100;
                DEST_POP: wr_d = 4'b1000;
                default:  wr_d = 4'b0000;
            endcase
        end
        wdata_d = (wr_d != 4'b0000) ? tail_data[BYTE_W-1:0] : 9'd0;

        rx_cnt_d   = rx_inc   ? rx_cnt_q + 16'd1   : rx_cnt_q;
        drop_cnt_d = drop_inc ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 4'd0;
            dest_q       <= DEST_NONE;
            rx_cnt_q     <= 16'd0;
            drop_cnt_q   <= 16'd0;
            format_err_q <= 1'b0;
            wdata_q      <= 9'd0;
            wr_q         <= 4'b0000;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            dest_q       <= dest_d;
            rx_cnt_q     <= rx_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            format_err_q <= format_err_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
        end
    end

    assign ov_fifo_wdata   = wdata_q;
    assign o_fifo_wr_nma   = wr_q[0];
    assign o_fifo_wr_osp   = wr_q[1];
    assign o_fifo_wr_tfp   = wr_q[2];
    assign o_fifo_wr_pop   = wr_q[3];
    assign ov_rx_pkt_cnt   = rx_cnt_q;
    assign ov_drop_pkt_cnt = drop_cnt_q;
    assign o_format_err    = format_err_q;

endmodule
